// File: rtl/match_unit.sv
// One window-match compute unit: accumulates sum(g), sum(g^2) and sum(f*g) for its
// four interleaved 16x16 g windows and streams the four result triples on request.
module match_unit #(
  parameter int UNIT_ID = 0,
  parameter int PIX_W   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             startsig,
  input  logic             lstart,
  input  logic             work,
  input  logic [15:0]      change,
  input  logic [PIX_W-1:0] gdata,
  input  logic [PIX_W-1:0] f_tap,
  input  logic             finalstart,
  input  logic             update,
  output logic [10:0]      out_gsum,
  output logic [13:0]      out_g2sum,
  output logic [13:0]      out_fgsum,
  output logic [1:0]       out_win,
  output logic             out_valid
);

  typedef enum logic [1:0] {IDLE = 2'd0, ROW = 2'd1, DONE = 2'd2} state_t;

  state_t             state_q, state_d;
  logic               work_q, lstart_q, startsig_q, update_q;
  logic               work_e, lstart_e, start_e, update_e;
  logic [1:0]         win_idx_q, win_idx_d;
  logic               win_active_q, win_active_d;
  logic               acc_en;
  logic [2:0]         out_idx_q, out_base;
  logic               emit;
  logic [2*PIX_W-1:0] g_ext, f_ext, g2_prod, fg_prod;
  logic [10:0]        gsum_q  [4];
  logic [13:0]        g2sum_q [4];
  logic [13:0]        fgsum_q [4];

  assign work_e   = work & ~work_q;
  assign lstart_e = lstart & ~lstart_q;
  assign start_e  = startsig & ~startsig_q;
  assign update_e = update & ~update_q;

  assign g_ext   = {{PIX_W{1'b0}}, gdata};
  assign f_ext   = {{PIX_W{1'b0}}, f_tap};
  assign g2_prod = g_ext * g_ext;
  assign fg_prod = f_ext * g_ext;

  // finalstart rewinds the sequencer in the same cycle, so a coincident update emits window 0
  assign out_base = finalstart ? 3'd0 : out_idx_q;
  assign emit     = update_e & ~start_e & ~out_base[2];

  always_comb begin
    state_d      = state_q;
    win_idx_d    = win_idx_q;
    win_active_d = win_active_q;
    acc_en       = 1'b0;
    if (start_e) begin
      state_d = IDLE;
    end else if (lstart_e) begin
      state_d      = ROW;
      win_idx_d    = 2'd0;
      win_active_d = 1'b0;
    end else if (work_e && state_q == ROW) begin
      if (change[UNIT_ID]) begin
        if (!win_active_q) begin
          win_active_d = 1'b1;
          win_idx_d    = 2'd0;
        end else if (win_idx_q == 2'd3) begin
          // fifth window boundary: the rest of the row belongs to no window of this unit
          win_active_d = 1'b0;
          state_d      = DONE;
        end else begin
          win_idx_d = win_idx_q + 2'd1;
        end
      end
      acc_en = win_active_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work_q       <= 1'b0;
      lstart_q     <= 1'b0;
      startsig_q   <= 1'b0;
      update_q     <= 1'b0;
      state_q      <= IDLE;
      win_idx_q    <= 2'd0;
      win_active_q <= 1'b0;
      out_idx_q    <= 3'd0;
      out_valid    <= 1'b0;
      out_gsum     <= '0;
      out_g2sum    <= '0;
      out_fgsum    <= '0;
      out_win      <= '0;
      for (int i = 0; i < 4; i++) begin
        gsum_q[i]  <= '0;
        g2sum_q[i] <= '0;
        fgsum_q[i] <= '0;
      end
    end else begin
      work_q       <= work;
      lstart_q     <= lstart;
      startsig_q   <= startsig;
      update_q     <= update;
      state_q      <= state_d;
      win_idx_q    <= win_idx_d;
      win_active_q <= win_active_d;

      if (start_e) begin
        for (int i = 0; i < 4; i++) begin
          gsum_q[i]  <= '0;
          g2sum_q[i] <= '0;
          fgsum_q[i] <= '0;
        end
      end else if (acc_en) begin
        gsum_q[win_idx_d]  <= gsum_q[win_idx_d] + 11'(gdata);
        g2sum_q[win_idx_d] <= g2sum_q[win_idx_d] + 14'(g2_prod);
        fgsum_q[win_idx_d] <= fgsum_q[win_idx_d] + 14'(fg_prod);
      end

      out_idx_q <= emit ? out_base + 3'd1 : out_base;
      out_valid <= emit;
      if (emit) begin
        out_gsum  <= gsum_q[out_base[1:0]];
        out_g2sum <= g2sum_q[out_base[1:0]];
        out_fgsum <= fgsum_q[out_base[1:0]];
        out_win   <= out_base[1:0];
      end
    end
  end

endmodule

// File: tb/tb_match_unit.sv
// Scoreboard bench: three units (UNIT_ID 0, 3, 15) share one stimulus stream; a
// column-arithmetic reference model predicts every result strobe.
module tb_match_unit;

  localparam int NU = 3;

  typedef struct {
    logic [10:0] g;
    logic [13:0] g2;
    logic [13:0] fg;
    logic [1:0]  w;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        startsig = 1'b0, lstart = 1'b0, work = 1'b0, finalstart = 1'b0, update = 1'b0;
  logic [15:0] change = '0;
  logic [2:0]  gdata = '0, f_tap = '0;

  logic [10:0] og  [NU];
  logic [13:0] og2 [NU];
  logic [13:0] ofg [NU];
  logic [1:0]  ow  [NU];
  logic        ov  [NU];

  exp_t q [NU][$];
  int   total = 0, bad = 0;
  bit   done = 1'b0, fin = 1'b0;

  // reference model state
  int mg [NU][4], mg2 [NU][4], mfg [NU][4];
  bit rowing;
  int xg, oidx;

  function automatic int uid(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 3 : 15);
  endfunction

  always #5 clk = ~clk;

  for (genvar k = 0; k < NU; k++) begin : g_u
    match_unit #(.UNIT_ID(k == 0 ? 0 : (k == 1 ? 3 : 15)), .PIX_W(3)) dut (
      .clk(clk), .rst_n(rst_n), .startsig(startsig), .lstart(lstart), .work(work),
      .change(change), .gdata(gdata), .f_tap(f_tap), .finalstart(finalstart), .update(update),
      .out_gsum(og[k]), .out_g2sum(og2[k]), .out_fgsum(ofg[k]), .out_win(ow[k]), .out_valid(ov[k])
    );
  end

  // monitor: pops on every strobe, otherwise checks that outputs hold the last result
  exp_t hv [NU];
  always @(negedge clk) begin
    exp_t e;
    for (int k = 0; k < NU; k++) begin
      if (!rst_n) begin
        q[k].delete();
        hv[k] = '{g: '0, g2: '0, fg: '0, w: '0};
        total++;
        if (ov[k] || og[k] != 0 || og2[k] != 0 || ofg[k] != 0 || ow[k] != 0) begin
          bad++;
          $display("FAIL reset_zero u%0d: got v=%0d g=%0d g2=%0d fg=%0d w=%0d, want all 0",
                   uid(k), ov[k], og[k], og2[k], ofg[k], ow[k]);
        end
      end else if (ov[k]) begin
        total++;
        if (q[k].size() == 0) begin
          bad++;
          $display("FAIL unexpected_strobe u%0d: got g=%0d w=%0d, want no strobe", uid(k), og[k], ow[k]);
          hv[k] = '{g: og[k], g2: og2[k], fg: ofg[k], w: ow[k]};
        end else begin
          e = q[k].pop_front();
          hv[k] = e;
          if (og[k] != e.g || og2[k] != e.g2 || ofg[k] != e.fg || ow[k] != e.w) begin
            bad++;
            $display("FAIL strobe u%0d: got g=%0d g2=%0d fg=%0d w=%0d, want g=%0d g2=%0d fg=%0d w=%0d",
                     uid(k), og[k], og2[k], ofg[k], ow[k], e.g, e.g2, e.fg, e.w);
          end
        end
      end else begin
        total++;
        if (og[k] != hv[k].g || og2[k] != hv[k].g2 || ofg[k] != hv[k].fg || ow[k] != hv[k].w) begin
          bad++;
          $display("FAIL hold u%0d: got g=%0d g2=%0d fg=%0d w=%0d, want g=%0d g2=%0d fg=%0d w=%0d",
                   uid(k), og[k], og2[k], ofg[k], ow[k], hv[k].g, hv[k].g2, hv[k].fg, hv[k].w);
        end
      end
    end
    if (done && !fin) begin
      fin = 1'b1;
      for (int k = 0; k < NU; k++) begin
        total++;
        if (q[k].size() != 0) begin
          bad++;
          $display("FAIL pending u%0d: got %0d strobes missing, want 0", uid(k), q[k].size());
        end
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int k = 0; k < NU; k++)
      for (int w = 0; w < 4; w++) begin
        mg[k][w] = 0; mg2[k][w] = 0; mfg[k][w] = 0;
      end
  endtask

  task automatic pix(input int g, input int f, input int hold);
    gdata  = 3'(g);
    f_tap  = 3'(f);
    change = 16'(1) << (xg % 16);
    work   = 1'b1;
    repeat (hold) step();
    work = 1'b0;
    step();
    if (rowing) begin
      for (int k = 0; k < NU; k++) begin
        if (xg >= uid(k) && (xg - uid(k)) / 16 <= 3) begin
          mg[k][(xg - uid(k)) / 16]  += g;
          mg2[k][(xg - uid(k)) / 16] += g * g;
          mfg[k][(xg - uid(k)) / 16] += f * g;
        end
      end
    end
    xg++;
  endtask

  task automatic do_start();
    startsig = 1'b1; step(); startsig = 1'b0; step();
    model_clear();
    rowing = 1'b0;
  endtask

  task automatic do_lstart();
    lstart = 1'b1; step(); lstart = 1'b0; step();
    rowing = 1'b1;
    xg = 0;
  endtask

  task automatic do_final();
    finalstart = 1'b1; step(); finalstart = 1'b0; step();
    oidx = 0;
  endtask

  task automatic do_update(input bit with_final, input bit with_start);
    update = 1'b1; finalstart = with_final; startsig = with_start;
    if (with_start) begin
      model_clear();
      rowing = 1'b0;
    end else begin
      if (with_final) oidx = 0;
      if (oidx < 4) begin
        for (int k = 0; k < NU; k++)
          q[k].push_back('{g: 11'(mg[k][oidx]), g2: 14'(mg2[k][oidx]), fg: 14'(mfg[k][oidx]), w: 2'(oidx)});
        oidx++;
      end
    end
    step();
    finalstart = 1'b0; startsig = 1'b0;
    if (with_final) oidx = with_start ? 0 : oidx;
    update = 1'b0;
    step();
  endtask

  task automatic do_reset();
    model_clear();
    rowing = 1'b0; oidx = 0; xg = 0;
    rst_n = 1'b0;
  endtask

  task automatic drain();
    repeat (4) step();
  endtask

  initial begin
    model_clear();
    rowing = 1'b0; xg = 0; oidx = 0;
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // single row, constant data: every unit ends up with 16 pixels per window except truncation rules
    do_start();
    do_lstart();
    for (int i = 0; i < 79; i++) pix(7, 2, 1);
    do_final();
    for (int i = 0; i < 5; i++) do_update(1'b0, 1'b0);
    drain();
    do_final();
    do_update(1'b0, 1'b0);
    do_update(1'b1, 1'b0);
    do_update(1'b0, 1'b0);
    drain();

    // full frame with maximum pixel values
    do_start();
    for (int r = 0; r < 16; r++) begin
      do_lstart();
      for (int i = 0; i < 79; i++) pix(7, 7, 1);
    end
    do_final();
    for (int i = 0; i < 4; i++) do_update(1'b0, 1'b0);
    drain();

    // mid-row startsig: only post-clear pixels survive
    do_start();
    do_lstart();
    for (int i = 0; i < 30; i++) pix(5, 3, 1);
    do_start();
    for (int i = 0; i < 10; i++) pix(6, 6, 1);
    do_lstart();
    for (int i = 0; i < 79; i++) pix(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 1);
    do_final();
    for (int i = 0; i < 4; i++) do_update(1'b0, 1'b0);
    drain();

    // randomized frames with held levels, combined events and random update counts
    for (int fr = 0; fr < 5; fr++) begin
      do_start();
      for (int r = 0; r < 16; r++) begin
        int len;
        len = int'($urandom_range(0, 79));
        do_lstart();
        for (int i = 0; i < len; i++) begin
          if ($urandom_range(0, 299) == 0) do_start();
          pix(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(1, 3)));
        end
      end
      if ($urandom_range(0, 1) == 1) begin
        do_final();
        do_update(1'b0, 1'b0);
      end else begin
        do_update(1'b1, 1'b0);
      end
      for (int i = 0; i < int'($urandom_range(2, 5)); i++) do_update(1'b0, 1'b0);
      drain();
    end

    // startsig coinciding with update: clear wins, no strobe
    do_final();
    do_update(1'b0, 1'b1);
    do_update(1'b0, 1'b0);
    drain();

    // reset in the middle of a work burst, then updates emit zeros without a startsig
    do_start();
    do_lstart();
    for (int i = 0; i < 20; i++) pix(7, 7, 1);
    work = 1'b1; gdata = 3'd7; f_tap = 3'd7; step();
    do_reset();
    work = 1'b0; step();
    work = 1'b1; step();
    work = 1'b0; step();
    step();
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 20; i++) pix(7, 7, 1);
    for (int i = 0; i < 5; i++) do_update(1'b0, 1'b0);
    drain();

    done = 1'b1;
    repeat (3) step();
  end

endmodule

// File: doc/match_unit.md
Name: match_unit

Overview:
- One of 16 parallel window-match compute units sitting downstream of the f/g controller.
- Unit UNIT_ID owns the four 16x16 g windows whose start columns are UNIT_ID, UNIT_ID+16, UNIT_ID+32 and UNIT_ID+48.
- For each window it accumulates sum(g), sum(g^2) and sum(f*g) over all 16 rows, using the controller's broadcast strobes.
- After the controller's end-of-window sequence it serially emits the four result triples to the match/compare stage.

Parameters:
- UNIT_ID, 0, unit index 0..15; selects the change bit and the window start columns.
- PIX_W, 3, pixel width in bits.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- startsig  in  1  rising edge clears all accumulators (start of a new f window).
- lstart  in  1  rising edge marks a new image row.
- work  in  1  rising edge is one pixel step; gdata, f_tap and change are stable while work is high.
- change  in  16  one-hot column phase (xg mod 16).
- gdata  in  PIX_W  current g pixel, broadcast to all units.
- f_tap  in  PIX_W  f-pipeline tap UNIT_ID; it is the f pixel aligned to this unit's active window.
- finalstart  in  1  high for one cycle when all 16 rows are done.
- update  in  1  rising edge requests the next result.
- out_gsum  out  11  sum of g for the emitted window.
- out_g2sum  out  14  sum of g^2.
- out_fgsum  out  14  sum of f*g.
- out_win  out  2  index (0..3) of the emitted window.
- out_valid  out  1  one-cycle strobe, high when the out_* registers are freshly loaded.

Behaviour:
- Edge detection:
  - work, lstart, startsig and update each have a registered previous-value flop, reset to 0.
  - Only rising edges act. A level held high never counts twice.
- Reset (async, rst_n=0):
  - All accumulators and all out_* registers go to 0.
  - win_idx = 0, win_active = 0, out_idx = 0, out_valid = 0.
  - Reset mid-row or mid-output aborts the operation. Nothing resumes until the next startsig edge.
- Accumulators:
  - Four triples: gsum[4] are 11-bit, g2sum[4] are 14-bit, fgsum[4] are 14-bit.
  - Products: g^2 and f*g are 6-bit, zero-extended.
  - Maximum values are 256*7 = 1792 and 256*49 = 12544, so no overflow in legal use. Sums wrap modulo width and no saturation is required.
- Row FSM (states IDLE, ROW, DONE):
  - startsig edge: clear all 12 accumulators, go to IDLE. This has priority over every other event in the same cycle.
  - lstart edge: win_active = 0, win_idx = 0, go to ROW.
  - work edge in ROW with change[UNIT_ID] = 1:
    - If win_active = 0, set win_active = 1 and keep win_idx = 0.
    - Otherwise increment win_idx.
    - If win_idx would pass 3, clear win_active, go to DONE and ignore the rest of the row.
  - Accumulate on a work edge in ROW when win_active is 1 after the update above:
    - gsum[win_idx] += gdata
    - g2sum[win_idx] += gdata*gdata
    - fgsum[win_idx] += f_tap*gdata
  - Columns before the first change[UNIT_ID] (xg < UNIT_ID) are not accumulated.
  - work edge in IDLE or DONE: no effect.
  - lstart edge in DONE: returns to ROW.
- Output sequencer:
  - finalstart high at a rising edge: out_idx = 0. The row FSM stays put.
  - update edge with out_idx <= 3:
    - out_gsum/out_g2sum/out_fgsum <= triple[out_idx].
    - out_win <= out_idx.
    - out_valid = 1 for exactly one cycle.
    - out_idx += 1.
  - update edge with out_idx = 4: ignored. Outputs hold and out_valid stays 0.
  - out_* hold their values between strobes.
- Simultaneous events:
  - finalstart and update edge together: out_idx reset first, then window 0 is emitted.
  - startsig and update together: the clear wins and no strobe is issued.
- Latency: a result is registered 1 clk after the update rising edge is sampled.

Test Plan:
- Reset: rst_n low during a work burst -> all outputs 0 and out_valid 0. After release, with no startsig, update edges emit zeros.
- Single row, UNIT_ID=3: startsig, lstart, then 79 work edges, xg=0..78, with change one-hot at xg mod 16, gdata=7, f_tap=2.
  - Columns 0-2 are skipped; windows 3/19/35/51 each take 16 pixels.
  - Then finalstart and 4 update edges -> each window gives gsum=112, g2sum=784, fgsum=224, out_win=0,1,2,3.
- Full frame, UNIT_ID=0: 16 rows of gdata=7, f_tap=7 -> every window gives gsum=1792, g2sum=12544, fgsum=12544; no wrap.
- UNIT_ID=15: the last window spans xg 63..78 and is accumulated. UNIT_ID=0: columns 64..78 (win_idx would reach 4) are ignored; window 3 gsum is unchanged.
- A fifth update edge after finalstart -> no out_valid and outputs hold window 3. A new finalstart -> the next update emits window 0 again.
- startsig edge mid-row -> accumulators clear. The next lstart and row start fresh, and results reflect only post-clear pixels.
